// File: rtl/my_i2c_target_if.sv
// Bus-side and user-side signals of the my_i2c_target I2C target endpoint.
interface my_i2c_target_if;
    logic       enable;
    logic [6:0] slave_addr;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       sda_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       start_det;
    logic       stop_det;
    logic       rd_wr;
    logic       addressed;
    logic       busy;

    modport slave (
        input  enable, slave_addr, scl_in, sda_in, tx_data,
        output sda_oe, sda_out, rx_data, rx_valid, tx_req,
               start_det, stop_det, rd_wr, addressed, busy
    );

    modport master (
        output enable, slave_addr, scl_in, sda_in, tx_data,
        input  sda_oe, sda_out, rx_data, rx_valid, tx_req,
               start_det, stop_det, rd_wr, addressed, busy
    );
endinterface

// File: rtl/my_i2c_target.sv
// I2C target endpoint: 7-bit address match, byte write/read, open-drain SDA, no stretching.
// Optional input glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module my_i2c_target #(
    parameter int unsigned FILTER_LEN = 3
) (
    input logic            clk,
    input logic            resetn,
    my_i2c_target_if.slave io
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_IGNORE
    } state_t;

    logic [1:0] r_scl_sync, r_sda_sync;
    logic       w_scl, w_sda;
    logic       r_scl_q, r_sda_q;
    logic       r_scl_rise, r_scl_fall, r_start, r_stop;

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], io.scl_in};
            r_sda_sync <= {r_sda_sync[0], io.sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int unsigned FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    logic [FCW-1:0] r_scl_cnt, r_sda_cnt;
    logic           r_scl_filt, r_sda_filt;

    // A line flips only after FILTER_LEN consecutive samples disagree with it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            if (r_scl_sync[1] == r_scl_filt) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FCW'(FILTER_LEN - 1)) begin
                r_scl_filt <= r_scl_sync[1];
                r_scl_cnt  <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + FCW'(1);
            end
            if (r_sda_sync[1] == r_sda_filt) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FCW'(FILTER_LEN - 1)) begin
                r_sda_filt <= r_sda_sync[1];
                r_sda_cnt  <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + FCW'(1);
            end
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    wire w_unused_filter_len = ^32'(FILTER_LEN);
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    // Registered bus events; r_sda_q is the SDA level aligned with each event
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_q    <= w_scl;
            r_sda_q    <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_q;
            r_scl_fall <= ~w_scl & r_scl_q;
            r_start    <= w_scl & r_scl_q & r_sda_q & ~w_sda;
            r_stop     <= w_scl & r_scl_q & ~r_sda_q & w_sda;
        end
    end

    state_t     r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_tx_req, w_tx_req_nxt;
    logic       r_start_det, w_start_det_nxt;
    logic       r_stop_det, w_stop_det_nxt;
    logic       r_rd_wr, w_rd_wr_nxt;
    logic       r_addressed, w_addressed_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_mack, w_mack_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 4'd0;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_rd_wr     <= 1'b0;
            r_addressed <= 1'b0;
            r_busy      <= 1'b0;
            r_mack      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_req    <= w_tx_req_nxt;
            r_start_det <= w_start_det_nxt;
            r_stop_det  <= w_stop_det_nxt;
            r_rd_wr     <= w_rd_wr_nxt;
            r_addressed <= w_addressed_nxt;
            r_busy      <= w_busy_nxt;
            r_mack      <= w_mack_nxt;
        end
    end

    // Next state and outputs; START/STOP override any SCL event in the same cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_sda_oe_nxt    = r_sda_oe;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_tx_req_nxt    = 1'b0;
        w_start_det_nxt = 1'b0;
        w_stop_det_nxt  = 1'b0;
        w_rd_wr_nxt     = r_rd_wr;
        w_addressed_nxt = r_addressed;
        w_mack_nxt      = r_mack;

        if (!io.enable) begin
            w_state_nxt     = S_IDLE;
            w_sda_oe_nxt    = 1'b0;
            w_addressed_nxt = 1'b0;
        end else if (r_start) begin
            w_state_nxt     = S_ADDR;
            w_bit_cnt_nxt   = 4'd0;
            w_sda_oe_nxt    = 1'b0;
            w_addressed_nxt = 1'b0;
            w_start_det_nxt = 1'b1;
        end else if (r_stop) begin
            w_state_nxt     = S_IDLE;
            w_sda_oe_nxt    = 1'b0;
            w_addressed_nxt = 1'b0;
            w_stop_det_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (r_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], r_sda_q};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (r_scl_fall && r_bit_cnt == 4'd8) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_shift[7:1] == io.slave_addr) begin
                            w_rd_wr_nxt     = r_shift[0];
                            w_sda_oe_nxt    = 1'b1;
                            w_addressed_nxt = 1'b1;
                            w_state_nxt     = S_ADDR_ACK;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (r_scl_rise) begin
                        w_tx_req_nxt = r_rd_wr;
                    end else if (r_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_rd_wr) begin
                            w_shift_nxt  = io.tx_data;
                            w_sda_oe_nxt = ~io.tx_data[7];
                            w_state_nxt  = S_TX_BYTE;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_RX_BYTE;
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (r_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], r_sda_q};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (r_scl_fall && r_bit_cnt == 4'd8) begin
                        w_rx_data_nxt  = r_shift;
                        w_rx_valid_nxt = 1'b1;
                        w_sda_oe_nxt   = 1'b1;
                        w_bit_cnt_nxt  = 4'd0;
                        w_state_nxt    = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (r_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    // MSB already on the bus; each fall presents the next bit, the 8th releases
                    if (r_scl_fall) begin
                        if (r_bit_cnt == 4'd7) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = S_TX_ACK;
                        end else begin
                            w_sda_oe_nxt  = ~r_shift[6];
                            w_shift_nxt   = {r_shift[6:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (r_scl_rise) begin
                        w_mack_nxt   = ~r_sda_q;
                        w_tx_req_nxt = ~r_sda_q;
                    end else if (r_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_mack) begin
                            w_shift_nxt  = io.tx_data;
                            w_sda_oe_nxt = ~io.tx_data[7];
                            w_state_nxt  = S_TX_BYTE;
                        end else begin
                            w_addressed_nxt = 1'b0;
                            w_state_nxt     = S_IGNORE;
                        end
                    end
                end
                S_IDLE, S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign io.sda_oe    = r_sda_oe;
    assign io.sda_out   = 1'b0;
    assign io.rx_data   = r_rx_data;
    assign io.rx_valid  = r_rx_valid;
    assign io.tx_req    = r_tx_req;
    assign io.start_det = r_start_det;
    assign io.stop_det  = r_stop_det;
    assign io.rd_wr     = r_rd_wr;
    assign io.addressed = r_addressed;
    assign io.busy      = r_busy;
endmodule

// File: tb/tb_my_i2c_target.sv
// Bench for my_i2c_target: bit-level bus master, transaction-level expectation model, per-cycle monitor.
`timescale 1ns/1ps
module tb_my_i2c_target;
    localparam int unsigned Q = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic r_scl = 1'b1;
    logic r_msda = 1'b1;

    always #5 clk = ~clk;

    my_i2c_target_if bus();
    assign bus.scl_in = r_scl;
    assign bus.sda_in = r_msda & ~bus.sda_oe;

    my_i2c_target #(.FILTER_LEN(3)) dut (.clk(clk), .resetn(resetn), .io(bus));

    int checks = 0;
    int errors = 0;

    // Transaction-level model of what the target must do
    bit         m_addr_phase = 1'b0;
    bit         m_sel = 1'b0;
    bit         m_rw = 1'b0;
    bit         m_idle = 1'b1;
    int         exp_start = 0, exp_stop = 0, exp_txreq = 0;
    int         n_start = 0, n_stop = 0, n_txreq = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] drv_tx[$];
    logic [7:0] m_last_rx = 8'h00;
    logic       r_prev_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wclk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_clk(input logic b, input bit glitch, output logic s);
        wclk(Q); r_msda = b;
        wclk(Q); r_scl = 1'b1;
        wclk(Q); s = bus.sda_in;
        if (glitch) begin
            r_scl = 1'b0; wclk(2); r_scl = 1'b1;
        end
        wclk(Q); r_scl = 1'b0;
    endtask

    task automatic do_start();
        m_idle = 1'b0;
        r_msda = 1'b1; wclk(Q);
        r_scl = 1'b1;  wclk(Q);
        r_msda = 1'b0; wclk(Q);
        r_scl = 1'b0;
        if (bus.enable) begin
            exp_start++;
            m_addr_phase = 1'b1;
        end
        m_sel = 1'b0;
    endtask

    task automatic do_stop();
        wclk(Q); r_msda = 1'b0;
        wclk(Q); r_scl = 1'b1;
        wclk(Q); r_msda = 1'b1;
        wclk(Q);
        if (bus.enable) exp_stop++;
        m_sel = 1'b0;
        m_addr_phase = 1'b0;
        wclk(Q);
        m_idle = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch);
        logic s;
        bit   exp_ack;
        bit   was_addr;
        was_addr = m_addr_phase;
        if (m_addr_phase) begin
            m_sel = (b[7:1] == bus.slave_addr);
            m_rw = b[0];
            exp_ack = m_sel;
            m_addr_phase = 1'b0;
        end else begin
            exp_ack = m_sel && !m_rw;
            if (exp_ack) exp_rx.push_back(b);
        end
        for (int i = 7; i >= 0; i--) bit_clk(b[i], glitch && (i == 4), s);
        bit_clk(1'b1, 1'b0, s);
        chk("ack", 32'(!s), 32'(exp_ack));
        if (was_addr) begin
            chk("addressed", 32'(bus.addressed), 32'(m_sel));
            if (m_sel) chk("rd_wr", 32'(bus.rd_wr), 32'(m_rw));
        end
    endtask

    task automatic read_byte(input bit mack, output logic [7:0] d);
        logic       s;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_clk(!mack, 1'b0, s);
        if (m_sel && m_rw) begin
            exp_txreq++;
            e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'hEE;
            chk("rd_data", 32'(d), 32'(e));
        end
        if (!mack) m_sel = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        drv_tx.push_back(b);
        exp_tx.push_back(b);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_start_det"}, 32'(n_start), 32'(exp_start));
        chk({tag, "_stop_det"}, 32'(n_stop), 32'(exp_stop));
        chk({tag, "_tx_req"}, 32'(n_txreq), 32'(exp_txreq));
        chk({tag, "_rx_pending"}, 32'(exp_rx.size()), 32'(0));
    endtask

    // User side: answer each tx_req with the next queued byte
    initial begin
        bus.tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.tx_req) bus.tx_data = (drv_tx.size() != 0) ? drv_tx.pop_front() : 8'hEE;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (resetn) begin
            chk("sda_out", 32'(bus.sda_out), 32'(0));
            if (bus.rx_valid) begin
                if (exp_rx.size() == 0) chk("rx_valid_spurious", 32'(bus.rx_valid), 32'(0));
                else m_last_rx = exp_rx.pop_front();
            end
            chk("rx_data", 32'(bus.rx_data), 32'(m_last_rx));
            if (!m_sel) chk("sda_oe_released", 32'(bus.sda_oe), 32'(0));
            if (m_idle || !r_prev_en) begin
                chk("busy_idle", 32'(bus.busy), 32'(0));
                chk("addressed_idle", 32'(bus.addressed), 32'(0));
            end
            if (!r_prev_en) begin
                chk("strobes_disabled",
                    32'({bus.rx_valid, bus.tx_req, bus.start_det, bus.stop_det, bus.sda_oe}), 32'(0));
            end
            n_start += int'(bus.start_det);
            n_stop  += int'(bus.stop_det);
            n_txreq += int'(bus.tx_req);
        end
        r_prev_en = bus.enable;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] d0, d1;
        logic       s;
        bus.enable = 1'b1;
        bus.slave_addr = 7'h3C;
        resetn = 1'b0;
        wclk(3);
        chk("rst_outputs",
            32'({bus.sda_oe, bus.sda_out, bus.rx_valid, bus.tx_req, bus.start_det,
                 bus.stop_det, bus.rd_wr, bus.addressed, bus.busy}), 32'(0));
        chk("rst_rx_data", 32'(bus.rx_data), 32'(0));
        resetn = 1'b1;
        wclk(10);

        // Write two bytes
        do_start();
        chk("t1_busy", 32'(bus.busy), 32'(1));
        write_byte(8'h78, 1'b0);
        write_byte(8'hA5, 1'b0);
        chk("t1_rx_a5", 32'(bus.rx_data), 32'(8'hA5));
        write_byte(8'h01, 1'b0);
        do_stop();
        chk("t1_rx_last", 32'(bus.rx_data), 32'(8'h01));
        check_counts("t1");
        wclk(20);

        // Wrong address
        do_start();
        write_byte(8'h7A, 1'b0);
        chk("t2_addressed", 32'(bus.addressed), 32'(0));
        do_stop();
        check_counts("t2");
        wclk(20);

        // Read two bytes, ACK then NACK
        push_tx(8'h5A);
        push_tx(8'hC3);
        do_start();
        write_byte(8'h79, 1'b0);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        chk("t3_byte0", 32'(d0), 32'(8'h5A));
        chk("t3_byte1", 32'(d1), 32'(8'hC3));
        chk("t3_released", 32'(bus.sda_oe), 32'(0));
        do_stop();
        check_counts("t3");
        wclk(20);

        // Write then repeated START into a one-byte read
        push_tx(8'h96);
        do_start();
        write_byte(8'h78, 1'b0);
        chk("t4_rdwr_w", 32'(bus.rd_wr), 32'(0));
        write_byte(8'h10, 1'b0);
        do_start();
        write_byte(8'h79, 1'b0);
        chk("t4_rdwr_r", 32'(bus.rd_wr), 32'(1));
        read_byte(1'b0, d0);
        chk("t4_byte", 32'(d0), 32'(8'h96));
        do_stop();
        check_counts("t4");
        wclk(20);

        // STOP after four data bits, then a normal write
        do_start();
        write_byte(8'h78, 1'b0);
        bit_clk(1'b1, 1'b0, s);
        bit_clk(1'b0, 1'b0, s);
        bit_clk(1'b1, 1'b0, s);
        bit_clk(1'b0, 1'b0, s);
        do_stop();
        chk("t5_rx_held", 32'(bus.rx_data), 32'(8'h10));
        do_start();
        write_byte(8'h78, 1'b0);
        write_byte(8'h3C, 1'b0);
        do_stop();
        chk("t5_rx_after", 32'(bus.rx_data), 32'(8'h3C));
        check_counts("t5");
        wclk(20);

        // Disable mid-byte, finish the byte and STOP while disabled, then re-enable
        do_start();
        write_byte(8'h78, 1'b0);
        bit_clk(1'b0, 1'b0, s);
        bit_clk(1'b1, 1'b0, s);
        bit_clk(1'b0, 1'b0, s);
        bus.enable = 1'b0;
        m_sel = 1'b0;
        wclk(4);
        chk("t6_busy_off", 32'(bus.busy), 32'(0));
        for (int i = 0; i < 5; i++) bit_clk(1'b1, 1'b0, s);
        bit_clk(1'b1, 1'b0, s);
        chk("t6_no_ack", 32'(s), 32'(1));
        do_stop();
        bus.enable = 1'b1;
        wclk(10);
        do_start();
        write_byte(8'h78, 1'b0);
        write_byte(8'h5A, 1'b0);
        do_stop();
        chk("t6_rx", 32'(bus.rx_data), 32'(8'h5A));
        check_counts("t6");
        wclk(20);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // Short SCL low pulse inside a data bit must be rejected
        do_start();
        write_byte(8'h78, 1'b0);
        write_byte(8'hA5, 1'b1);
        do_stop();
        chk("t7_glitch_rx", 32'(bus.rx_data), 32'(8'hA5));
        check_counts("t7");
        wclk(20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
